mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The module SHALL have parameter ADDR_BITS, default 20, giving the word-address width of the memory port.
REQ-002 The module SHALL have input clk, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have input rst_n, 1 bit: reset, asynchronous and active-low.
REQ-004 The module SHALL have input req_valid, 1 bit: a request is presented.
REQ-005 The module SHALL have output req_ready, 1 bit: a request can be accepted.
REQ-006 The module SHALL have input req_we, 1 bit: 1 = store, 0 = load.
REQ-007 The module SHALL have input req_size, 2 bits: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 The module SHALL have input req_unsigned, 1 bit: zero-extend a load (1) or sign-extend it (0).
REQ-009 The module SHALL have input req_addr, 32 bits: the byte address.
REQ-010 The module SHALL have input req_wdata, 32 bits: store data, right-aligned.
REQ-011 The module SHALL have output rsp_valid, 1 bit: a response is presented.
REQ-012 The module SHALL have input rsp_ready, 1 bit: the consumer accepts the response.
REQ-013 The module SHALL have output rsp_rdata, 32 bits: the extended load data (0 for stores and errors).
REQ-014 The module SHALL have output rsp_err, 1 bit: the access was misaligned, out of range or of illegal size.
REQ-015 The module SHALL have output mem_a, ADDR_BITS bits: the word address to the memory.
REQ-016 The module SHALL have output mem_we, 4 bits: byte write enables; bit k writes bits [8k+7:8k].
REQ-017 The module SHALL have output mem_d, 32 bits: write data to the memory.
REQ-018 The module SHALL have input mem_spo, 32 bits: combinational read data of mem[mem_a].

Function
REQ-019 The module SHALL use an FSM with states IDLE, ACCESS and RESP.
REQ-020 req_ready SHALL be 1 only in IDLE; handshake = req_valid & req_ready; on handshake register all req_* fields and go to ACCESS.
REQ-021 ACCESS SHALL last exactly one cycle and then go to RESP; RESP SHALL hold until rsp_valid & rsp_ready, then go to IDLE.
REQ-022 Latency: handshake at edge N SHALL give rsp_valid=1 in the cycle after edge N+1; at most one request is outstanding; throughput is one request per 3 cycles.
REQ-023 mem_a SHALL equal the registered addr[ADDR_BITS+1:2] in every state.
REQ-024 Error SHALL be set when req_size=11, or size=01 with addr[0]=1, or size=10 with addr[1:0]!=0, or addr[31:ADDR_BITS+2]!=0.
REQ-025 mem_we SHALL be nonzero only in ACCESS with a store and no error; the base mask (byte 0001, half 0011, word 1111) SHALL be shifted left by addr[1:0].
REQ-026 mem_d SHALL replicate wdata[7:0] into all four bytes for a byte store, wdata[15:0] into both halves for a half store, and equal wdata for a word store.
REQ-027 For a load, mem_spo SHALL be captured at the edge that ends ACCESS.
REQ-028 A byte load SHALL select lane addr[1:0] and a half load lane addr[1]; the result SHALL be extended to 32 bits per req_unsigned.
REQ-029 rsp_rdata and rsp_err SHALL be registered and stable while rsp_valid=1 and rsp_ready=0.
REQ-030 On error, the response SHALL have rsp_err=1, rsp_rdata=0 and no memory write.
REQ-031 A store response SHALL have rsp_rdata=0.
REQ-032 req_valid arriving during ACCESS or RESP SHALL be ignored (req_ready=0) and SHALL NOT be lost by the requester's protocol.

Reset
REQ-033 rst_n=0 SHALL asynchronously force IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_a=0, mem_d=0.
REQ-034 Reset during ACCESS or RESP SHALL abort the access: no write at any later edge, and the response is dropped.

Verification
REQ-035 Word store 0x12345678 @0x100, then word load @0x100 -> mem_a=0x40, mem_we=1111 for one cycle; load rsp_rdata=0x12345678, rsp_err=0.
REQ-036 Byte store 0xAB @0x103 -> mem_we=1000, mem_d=0xABABABAB; signed byte load @0x103 -> 0xFFFFFFAB; unsigned byte load @0x103 -> 0x000000AB.
REQ-037 Memory word 0x8001_1234: signed half load @0x102 -> 0xFFFF8001; unsigned half load @0x100 -> 0x00001234.
REQ-038 Word load @0x102, half store @0x101, size=11, and address 0x0040_0000 (ADDR_BITS=20) -> each gives rsp_err=1, rsp_rdata=0, mem_we=0 throughout.
REQ-039 rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stable, req_ready=0; the first rsp_ready=1 returns to IDLE with the next edge.
REQ-040 rst_n pulsed low during ACCESS of a store -> mem_we=0 immediately, the memory word is unchanged, no rsp_valid, req_ready=1.

Source files
------------

// File: rtl/mem_access_if.sv
// mem_access_if: groups the request, response and memory-port signals of
// mem_access_unit.
//   master modport : the requester / memory side (testbench or fabric)
//   slave  modport : the memory access unit itself
//   req_*  : request handshake (valid/ready) plus we, size, unsigned, addr, wdata
//   rsp_*  : response handshake (valid/ready) plus rdata, err
//   mem_*  : word address, byte write enables, write data, combinational read data
interface mem_access_if #(parameter int ADDR_BITS = 20);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [1:0]           req_size;
  logic                 req_unsigned;
  logic [31:0]          req_addr;
  logic [31:0]          req_wdata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [31:0]          rsp_rdata;
  logic                 rsp_err;
  logic [ADDR_BITS-1:0] mem_a;
  logic [3:0]           mem_we;
  logic [31:0]          mem_d;
  logic [31:0]          mem_spo;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output rsp_ready, mem_spo,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_a, mem_we, mem_d
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  rsp_ready, mem_spo,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_a, mem_we, mem_d
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store unit in front of a word-wide
// memory with combinational read (mem_spo) and byte write enables.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mem_access_if.slave (request, response and memory port)
// Sequence per request: IDLE (handshake) -> ACCESS (one cycle, write strobe
// or read capture) -> RESP (held until rsp_ready).
module mem_access_unit #(
  parameter int ADDR_BITS = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_access_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t               st;
  logic                 r_we;
  logic                 r_uns;
  logic                 r_err;
  logic [1:0]           r_size;
  logic [ADDR_BITS+1:0] r_addr;

  logic                 req_err;
  logic [3:0]           base_mask;
  logic [3:0]           st_mask;
  logic [31:0]          st_data;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic [31:0]          ld_data;

  assign bus.mem_a = r_addr[ADDR_BITS+1:2];

  // Request decode: error check, write mask and lane-replicated store data.
  always_comb begin
    req_err   = (bus.req_addr >> (ADDR_BITS + 2)) != 32'd0;
    base_mask = 4'b0000;
    st_data   = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        base_mask = 4'b0001;
        st_data   = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        base_mask = 4'b0011;
        st_data   = {2{bus.req_wdata[15:0]}};
        if (bus.req_addr[0]) req_err = 1'b1;
      end
      2'b10: begin
        base_mask = 4'b1111;
        if (bus.req_addr[1:0] != 2'b00) req_err = 1'b1;
      end
      default: req_err = 1'b1;
    endcase
    st_mask = base_mask << bus.req_addr[1:0];
  end

  // Load lane select and extension from the registered request.
  always_comb begin
    case (r_addr[1:0])
      2'd0:    ld_byte = bus.mem_spo[7:0];
      2'd1:    ld_byte = bus.mem_spo[15:8];
      2'd2:    ld_byte = bus.mem_spo[23:16];
      default: ld_byte = bus.mem_spo[31:24];
    endcase
    ld_half = r_addr[1] ? bus.mem_spo[31:16] : bus.mem_spo[15:0];
    case (r_size)
      2'b00:   ld_data = r_uns ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = r_uns ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = bus.mem_spo;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st            <= IDLE;
      r_we          <= 1'b0;
      r_uns         <= 1'b0;
      r_err         <= 1'b0;
      r_size        <= 2'b00;
      r_addr        <= '0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 32'd0;
      bus.rsp_err   <= 1'b0;
      bus.mem_we    <= 4'b0000;
      bus.mem_d     <= 32'd0;
    end else begin
      case (st)
        IDLE: if (bus.req_valid) begin
          r_we          <= bus.req_we;
          r_uns         <= bus.req_unsigned;
          r_err         <= req_err;
          r_size        <= bus.req_size;
          r_addr        <= bus.req_addr[ADDR_BITS+1:0];
          // Write strobe is armed here so it is visible for exactly the ACCESS cycle.
          bus.mem_we    <= (bus.req_we && !req_err) ? st_mask : 4'b0000;
          bus.mem_d     <= st_data;
          bus.req_ready <= 1'b0;
          st            <= ACCESS;
        end
        ACCESS: begin
          bus.mem_we    <= 4'b0000;
          bus.rsp_valid <= 1'b1;
          bus.rsp_err   <= r_err;
          bus.rsp_rdata <= (r_we || r_err) ? 32'd0 : ld_data;
          st            <= RESP;
        end
        RESP: if (bus.rsp_ready) begin
          bus.rsp_valid <= 1'b0;
          bus.req_ready <= 1'b1;
          st            <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed bench for mem_access_unit with a behavioural
// word memory (combinational read, byte-enabled write on the rising edge).
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  mem_access_if #(.ADDR_BITS(20)) bus ();

  mem_access_unit #(.ADDR_BITS(20)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:(1<<20)-1];
  assign bus.mem_spo = mem[bus.mem_a];
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (bus.mem_we[k]) mem[bus.mem_a][8*k +: 8] <= bus.mem_d[8*k +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request with rsp_ready held high: checks the ACCESS cycle outputs,
  // the response, and the return to IDLE.
  task automatic txn(input string tag, input logic we, input logic [1:0] size,
                     input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] exp_we, input logic [31:0] exp_d,
                     input logic [31:0] exp_rdata, input logic exp_err);
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.rsp_ready    = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk({tag, ".mem_a"}, 32'(bus.mem_a), 32'(addr[21:2]));
    chk({tag, ".mem_we"}, 32'(bus.mem_we), 32'(exp_we));
    if (exp_we != 4'b0000) chk({tag, ".mem_d"}, bus.mem_d, exp_d);
    chk({tag, ".ready_acc"}, 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, ".rdata"}, bus.rsp_rdata, exp_rdata);
    chk({tag, ".err"}, 32'(bus.rsp_err), 32'(exp_err));
    chk({tag, ".we_resp"}, 32'(bus.mem_we), 32'd0);
    @(posedge clk); #1;
    chk({tag, ".idle_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, ".idle_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    bus.rsp_ready = 1'b1;
    #12;
    chk("rst.req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst.rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst.rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst.mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst.mem_a", 32'(bus.mem_a), 32'd0);
    chk("rst.mem_d", bus.mem_d, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Word store / load
    txn("sw",   1, 2'b10, 0, 32'h100, 32'h12345678, 4'hF, 32'h12345678, 32'h0, 0);
    txn("lw",   0, 2'b10, 0, 32'h100, 32'h0, 4'h0, 32'h0, 32'h12345678, 0);
    // Byte store in the top lane, signed and unsigned reload
    txn("sb",   1, 2'b00, 0, 32'h103, 32'h000000AB, 4'h8, 32'hABABABAB, 32'h0, 0);
    txn("lb",   0, 2'b00, 0, 32'h103, 32'h0, 4'h0, 32'h0, 32'hFFFFFFAB, 0);
    txn("lbu",  0, 2'b00, 1, 32'h103, 32'h0, 4'h0, 32'h0, 32'h000000AB, 0);
    txn("lw2",  0, 2'b10, 0, 32'h100, 32'h0, 4'h0, 32'h0, 32'hAB345678, 0);
    // Half loads from 0x8001_1234
    txn("sw3",  1, 2'b10, 0, 32'h100, 32'h80011234, 4'hF, 32'h80011234, 32'h0, 0);
    txn("lh",   0, 2'b01, 0, 32'h102, 32'h0, 4'h0, 32'h0, 32'hFFFF8001, 0);
    txn("lhu",  0, 2'b01, 1, 32'h100, 32'h0, 4'h0, 32'h0, 32'h00001234, 0);
    // Half store to the upper half
    txn("sh",   1, 2'b01, 0, 32'h102, 32'h0000BEEF, 4'hC, 32'hBEEFBEEF, 32'h0, 0);
    txn("lw4",  0, 2'b10, 0, 32'h100, 32'h0, 4'h0, 32'h0, 32'hBEEF1234, 0);
    // Error cases
    txn("e_lw_mis", 0, 2'b10, 0, 32'h102, 32'h0, 4'h0, 32'h0, 32'h0, 1);
    txn("e_sh_mis", 1, 2'b01, 0, 32'h101, 32'h5555, 4'h0, 32'h0, 32'h0, 1);
    txn("e_size",   1, 2'b11, 0, 32'h100, 32'h7777, 4'h0, 32'h0, 32'h0, 1);
    txn("e_range",  1, 2'b10, 0, 32'h00400000, 32'h9999, 4'h0, 32'h0, 32'h0, 1);
    txn("lw5",  0, 2'b10, 0, 32'h100, 32'h0, 4'h0, 32'h0, 32'hBEEF1234, 0);

    // Backpressure: response held with rsp_ready low; a store offered meanwhile is ignored.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b01;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h102; bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    bus.req_we = 1'b1; bus.req_size = 2'b10; bus.req_addr = 32'h100;
    bus.req_wdata = 32'hCAFEF00D;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp.rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp.rdata", bus.rsp_rdata, 32'hFFFFBEEF);
      chk("bp.err", 32'(bus.rsp_err), 32'd0);
      chk("bp.req_ready", 32'(bus.req_ready), 32'd0);
      chk("bp.mem_we", 32'(bus.mem_we), 32'd0);
    end
    @(negedge clk); bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.release_valid", 32'(bus.rsp_valid), 32'd0);
    chk("bp.release_ready", 32'(bus.req_ready), 32'd1);
    txn("lw6",  0, 2'b10, 0, 32'h100, 32'h0, 4'h0, 32'h0, 32'hBEEF1234, 0);

    // Reset pulse during the ACCESS cycle of a store aborts it.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b10;
    bus.req_addr = 32'h100; bus.req_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("ra.we_before", 32'(bus.mem_we), 32'hF);
    rst_n = 1'b0; #1;
    chk("ra.mem_we", 32'(bus.mem_we), 32'd0);
    chk("ra.req_ready", 32'(bus.req_ready), 32'd1);
    chk("ra.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ra.no_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("ra.mem_word", mem[20'h40], 32'hBEEF1234);
    txn("lw7",  0, 2'b10, 0, 32'h100, 32'h0, 4'h0, 32'h0, 32'hBEEF1234, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
